// File: rtl/operand_stager.sv
// operand_stager
//   Operand front-end for an N x N systolic array. X-row and Y-column words
//   arrive LSB-first over SER_W-bit serial lanes and are stored in N banks of
//   DEPTH words per channel. A start request replays the stored words with a
//   diagonal skew: row r lags row 0 by r cycles, each word qualified by its
//   own valid bit. Stored data survives transfers, so replay needs no reload.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   load_en     in   serial data present; held high keeps the block loading
//   ser_x/ser_y in   SER_W-bit serial lanes, LSB-first
//   k_len       in   words per bank, sampled on entry to LOAD (0 or >DEPTH -> DEPTH)
//   start       in   replay request
//   out_x_flat  out  skewed X words, row r at [(r+1)*D_W-1 -: D_W]
//   out_y_flat  out  skewed Y words, same packing
//   out_valid   out  per-row valid
//   load_full   out  all N*k words written for the current load
//   busy        out  high while loading or transferring
//   done        out  one-cycle pulse after the last skewed word
module operand_stager #(
  parameter int D_W   = 8,
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int SER_W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [SER_W-1:0]           ser_x,
  input  logic [SER_W-1:0]           ser_y,
  input  logic [$clog2(DEPTH+1)-1:0] k_len,
  input  logic                       start,
  output logic [N*D_W-1:0]           out_x_flat,
  output logic [N*D_W-1:0]           out_y_flat,
  output logic [N-1:0]               out_valid,
  output logic                       load_full,
  output logic                       busy,
  output logic                       done
);

  localparam int K_W   = $clog2(DEPTH+1);
  localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int R_W   = (N > 1) ? $clog2(N) : 1;
  localparam int BEATS = D_W / SER_W;
  localparam int B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int T_W   = $clog2(N + DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q;
  logic [R_W-1:0]   row_q;
  logic [A_W-1:0]   addr_q;
  logic [B_W-1:0]   beat_q;
  logic [T_W-1:0]   t_q;
  logic             full_q, loaded_q, done_q;
  logic [D_W-1:0]   sr_x_q, sr_y_q;
  logic [D_W-1:0]   sr_x_d, sr_y_d;
  logic [D_W-1:0]   bank_x [N][DEPTH];
  logic [D_W-1:0]   bank_y [N][DEPTH];

  logic             beat_en, wr_en, last_wr, xfer_end;

  function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] kl);
    if (kl == '0 || int'(kl) > DEPTH) return K_W'(DEPTH);
    return kl;
  endfunction

  // New lane bits enter at the MSB end; after BEATS shifts the first lane
  // sample sits in the LSBs, giving LSB-first assembly.
  function automatic logic [D_W-1:0] shift_in(input logic [D_W-1:0] sr,
                                              input logic [SER_W-1:0] ser);
    logic [SER_W+D_W-1:0] cat;
    cat = {ser, sr};
    return cat[SER_W+D_W-1:SER_W];
  endfunction

  assign beat_en  = (state_q == LOAD) && load_en && !full_q;
  assign wr_en    = beat_en && (beat_q == B_W'(BEATS-1));
  assign last_wr  = (int'(addr_q) == int'(k_q) - 1);
  assign xfer_end = (int'(t_q) == N + int'(k_q));
  assign sr_x_d   = shift_in(sr_x_q, ser_x);
  assign sr_y_d   = shift_in(sr_y_q, ser_y);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_en)                state_d = LOAD;
        else if (start && loaded_q) state_d = XFER;
      end
      LOAD:    if (!load_en) state_d = IDLE;
      XFER:    if (xfer_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
      t_q      <= '0;
      full_q   <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_en) begin
            k_q    <= clamp_k(k_len);
            row_q  <= '0;
            addr_q <= '0;
            beat_q <= '0;
            full_q <= 1'b0;
          end else if (start && loaded_q) begin
            t_q <= '0;
          end
        end
        LOAD: begin
          if (beat_en) begin
            beat_q <= (beat_q == B_W'(BEATS-1)) ? '0 : beat_q + B_W'(1);
          end
          if (wr_en) begin
            if (last_wr) begin
              addr_q <= '0;
              if (row_q == R_W'(N-1)) begin
                full_q   <= 1'b1;
                loaded_q <= 1'b1;
              end else begin
                row_q <= row_q + R_W'(1);
              end
            end else begin
              addr_q <= addr_q + A_W'(1);
            end
          end
        end
        XFER: begin
          t_q <= t_q + T_W'(1);
          if (xfer_end) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Serial assembly and bank write; storage is never reset.
  always_ff @(posedge clk) begin
    if (beat_en) begin
      sr_x_q <= sr_x_d;
      sr_y_q <= sr_y_d;
      if (wr_en) begin
        bank_x[row_q][addr_q] <= sr_x_d;
        bank_y[row_q][addr_q] <= sr_y_d;
      end
    end
  end

  // ---- stage p0: skewed bank read, row r reads word t-r ----
  logic [N*D_W-1:0] rd_x_p0, rd_y_p0;
  logic [N-1:0]     vld_p0;

  always_comb begin
    int j;
    j       = 0;
    rd_x_p0 = '0;
    rd_y_p0 = '0;
    vld_p0  = '0;
    if (state_q == XFER) begin
      for (int r = 0; r < N; r++) begin
        j = int'(t_q) - r;
        if (j >= 0 && j < int'(k_q)) begin
          vld_p0[r]              = 1'b1;
          rd_x_p0[r*D_W +: D_W]  = bank_x[r][A_W'(j)];
          rd_y_p0[r*D_W +: D_W]  = bank_y[r][A_W'(j)];
        end
      end
    end
  end

  // ---- stage p1: registered read ----
  logic [N*D_W-1:0] x_p1, y_p1;
  logic [N-1:0]     vld_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= '0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    x_p1 <= rd_x_p0;
    y_p1 <= rd_y_p0;
  end

  // ---- stage p2: output register, data forced to zero outside its window ----
  logic [N*D_W-1:0] x_p2, y_p2;
  logic [N-1:0]     vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= '0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int r = 0; r < N; r++) begin
        x_p2[r*D_W +: D_W] <= vld_p1[r] ? x_p1[r*D_W +: D_W] : '0;
        y_p2[r*D_W +: D_W] <= vld_p1[r] ? y_p1[r*D_W +: D_W] : '0;
      end
    end
  end

  assign out_x_flat = x_p2;
  assign out_y_flat = y_p2;
  assign out_valid  = vld_p2;
  assign load_full  = full_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_operand_stager.sv
module tb_operand_stager;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst, load_en, start;
  logic [0:0]    ser_x, ser_y;
  logic [3:0]    k_len;
  logic [15:0]   out_x_flat, out_y_flat;
  logic [1:0]    out_valid;
  logic          load_full, busy, done;

  logic          load_en4, start4;
  logic [3:0]    ser_x4, ser_y4, k_len4;
  logic [15:0]   out_x4, out_y4;
  logic [1:0]    out_valid4;
  logic          load_full4, busy4, done4;

  operand_stager #(.D_W(DW), .N(N), .DEPTH(DP), .SER_W(1)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .ser_x(ser_x), .ser_y(ser_y),
    .k_len(k_len), .start(start), .out_x_flat(out_x_flat), .out_y_flat(out_y_flat),
    .out_valid(out_valid), .load_full(load_full), .busy(busy), .done(done));

  operand_stager #(.D_W(DW), .N(N), .DEPTH(DP), .SER_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_en(load_en4), .ser_x(ser_x4), .ser_y(ser_y4),
    .k_len(k_len4), .start(start4), .out_x_flat(out_x4), .out_y_flat(out_y4),
    .out_valid(out_valid4), .load_full(load_full4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: what each bank should hold and the active vector length.
  logic [7:0] mx [N][DP];
  logic [7:0] my [N][DP];
  int         mk;
  logic [7:0] src_x [16];
  logic [7:0] src_y [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serially loads 2*k words from src_x/src_y, then 'extra' junk beats.
  task automatic do_load(input int kl, input int extra);
    int k;
    k = (kl == 0 || kl > DP) ? DP : kl;
    k_len   = 4'(kl);
    load_en = 1'b1;
    step();
    for (int w = 0; w < N*k; w++) begin
      for (int b = 0; b < DW; b++) begin
        ser_x = src_x[w][b];
        ser_y = src_y[w][b];
        if (w == N*k-1 && b == DW-1) begin
          n_chk++;
          if (load_full !== 1'b0) $display("FAIL load_full_early: got %b want 0", load_full);
          else n_pass++;
        end
        step();
      end
    end
    n_chk++;
    if (load_full !== 1'b1) $display("FAIL load_full_set: got %b want 1", load_full);
    else n_pass++;
    for (int e = 0; e < extra; e++) begin
      ser_x = 1'($urandom);
      ser_y = 1'($urandom);
      step();
    end
    load_en = 1'b0;
    step();
    n_chk++;
    if (busy !== 1'b0 || load_full !== 1'b1)
      $display("FAIL load_exit: got busy=%b full=%b want busy=0 full=1", busy, load_full);
    else n_pass++;
    mk = k;
    for (int w = 0; w < N*k; w++) begin
      mx[w/k][w%k] = src_x[w];
      my[w/k][w%k] = src_y[w];
    end
  endtask

  task automatic rand_src();
    for (int i = 0; i < 16; i++) begin
      src_x[i] = 8'($urandom);
      src_y[i] = 8'($urandom);
    end
  endtask

  // One transfer checked cycle by cycle against the skew rule.
  task automatic run_xfer(input string nm, input bit ld_noise);
    logic [1:0]  ev;
    logic [15:0] ex, ey;
    int j;
    start = 1'b1;
    step();
    start = 1'b0;
    if (ld_noise) load_en = 1'b1;
    n_chk++;
    if (busy !== 1'b1 || out_valid !== 2'b00)
      $display("FAIL %s_begin: got busy=%b valid=%b want 1/00", nm, busy, out_valid);
    else n_pass++;
    for (int m = 1; m <= N + mk + 1; m++) begin
      step();
      ev = '0; ex = '0; ey = '0;
      for (int r = 0; r < N; r++) begin
        j = m - 2 - r;
        if (j >= 0 && j < mk) begin
          ev[r]        = 1'b1;
          ex[r*8 +: 8] = mx[r][j];
          ey[r*8 +: 8] = my[r][j];
        end
      end
      n_chk++;
      if (out_valid !== ev || out_x_flat !== ex || out_y_flat !== ey)
        $display("FAIL %s_data m=%0d: got v=%b x=%h y=%h want v=%b x=%h y=%h",
                 nm, m, out_valid, out_x_flat, out_y_flat, ev, ex, ey);
      else n_pass++;
      n_chk++;
      if (done !== (m == N + mk + 1) || busy !== (m < N + mk + 1))
        $display("FAIL %s_ctrl m=%0d: got done=%b busy=%b want done=%b busy=%b",
                 nm, m, done, busy, (m == N + mk + 1), (m < N + mk + 1));
      else n_pass++;
      if (m == N + mk) load_en = 1'b0;
    end
    step();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 2'b00)
      $display("FAIL %s_after: got done=%b busy=%b v=%b want 0/0/00", nm, done, busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; start = 1'b0; ser_x = '0; ser_y = '0; k_len = '0;
    load_en4 = 1'b0; start4 = 1'b0; ser_x4 = '0; ser_y4 = '0; k_len4 = '0;
    step(); step();
    rst = 1'b0;
    n_chk++;
    if (out_x_flat !== '0 || out_y_flat !== '0 || out_valid !== '0 ||
        load_full !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: got x=%h y=%h v=%b full=%b busy=%b done=%b want all 0",
               out_x_flat, out_y_flat, out_valid, load_full, busy, done);
    else n_pass++;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (busy !== 1'b0 || out_valid !== 2'b00)
        $display("FAIL reset_start_ignored c=%0d: got busy=%b v=%b want 0/00", i, busy, out_valid);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_spec_example();
    src_x[0] = 8'h11; src_x[1] = 8'h22; src_x[2] = 8'h33; src_x[3] = 8'h44;
    src_y[0] = 8'hA1; src_y[1] = 8'hA2; src_y[2] = 8'hA3; src_y[3] = 8'hA4;
    do_load(2, 0);
    run_xfer("example", 1'b0);
  endtask

  task automatic test_random_loads();
    int kls [3];
    kls[0] = $urandom_range(1, DP);
    kls[1] = 0;
    kls[2] = 12;
    for (int i = 0; i < 3; i++) begin
      rand_src();
      do_load(kls[i], 0);
      run_xfer("rand", 1'b0);
    end
  endtask

  task automatic test_overflow();
    rand_src();
    do_load(3, 5 + $urandom_range(0, 10));
    run_xfer("overflow", 1'b0);
  endtask

  task automatic test_partial();
    k_len   = 4'(mk);
    load_en = 1'b1;
    step();
    for (int b = 0; b < 3; b++) begin
      ser_x = 1'($urandom);
      ser_y = 1'($urandom);
      step();
    end
    load_en = 1'b0;
    step();
    n_chk++;
    if (load_full !== 1'b0 || busy !== 1'b0)
      $display("FAIL partial_state: got full=%b busy=%b want 0/0", load_full, busy);
    else n_pass++;
    run_xfer("partial_keep", 1'b0);
    rand_src();
    do_load(2, 0);
    run_xfer("partial_reload", 1'b0);
  endtask

  task automatic test_replay();
    run_xfer("replay1", 1'b0);
    run_xfer("replay_ld", 1'b1);
    run_xfer("replay2", 1'b0);
  endtask

  task automatic test_back_to_back();
    bit seen;
    start = 1'b1;
    step();
    for (int m = 1; m <= N + mk + 4; m++) begin
      step();
      if (m == N + mk + 1) begin
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0)
          $display("FAIL b2b_done: got done=%b busy=%b want 1/0", done, busy);
        else n_pass++;
      end
      if (m == N + mk + 2) begin
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0)
          $display("FAIL b2b_restart: got busy=%b done=%b want 1/0", busy, done);
        else n_pass++;
      end
      if (m == N + mk + 4) begin
        n_chk++;
        if (out_valid !== 2'b01 || out_x_flat[7:0] !== mx[0][0] || out_y_flat[7:0] !== my[0][0])
          $display("FAIL b2b_first_word: got v=%b x=%h y=%h want v=01 x=%h y=%h",
                   out_valid, out_x_flat[7:0], out_y_flat[7:0], mx[0][0], my[0][0]);
        else n_pass++;
      end
    end
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL b2b_second_done: got no done want done within 40 cycles");
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_xfer();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
        out_x_flat !== '0 || out_y_flat !== '0)
      $display("FAIL midrst_outputs: got v=%b busy=%b done=%b x=%h y=%h want all 0",
               out_valid, busy, done, out_x_flat, out_y_flat);
    else n_pass++;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (busy !== 1'b0 || out_valid !== 2'b00)
        $display("FAIL midrst_start_ignored c=%0d: got busy=%b v=%b want 0/00", i, busy, out_valid);
      else n_pass++;
      step();
    end
    rand_src();
    do_load(1, 0);
    run_xfer("midrst_reload", 1'b0);
  endtask

  task automatic test_ser4();
    logic [3:0] nx [4];
    logic [3:0] ny [4];
    nx[0] = 4'h5; nx[1] = 4'hA; nx[2] = 4'h3; nx[3] = 4'hC;
    ny[0] = 4'h1; ny[1] = 4'h2; ny[2] = 4'h7; ny[3] = 4'h8;
    k_len4   = 4'd1;
    load_en4 = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      ser_x4 = nx[b];
      ser_y4 = ny[b];
      n_chk++;
      if (load_full4 !== 1'b0) $display("FAIL ser4_full_early b=%0d: got %b want 0", b, load_full4);
      else n_pass++;
      step();
    end
    n_chk++;
    if (load_full4 !== 1'b1) $display("FAIL ser4_full: got %b want 1", load_full4);
    else n_pass++;
    load_en4 = 1'b0;
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    n_chk++;
    if (out_valid4 !== 2'b00) $display("FAIL ser4_c1: got v=%b want 00", out_valid4);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid4 !== 2'b01 || out_x4 !== 16'h00A5 || out_y4 !== 16'h0021)
      $display("FAIL ser4_row0: got v=%b x=%h y=%h want v=01 x=00a5 y=0021", out_valid4, out_x4, out_y4);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid4 !== 2'b10 || out_x4 !== 16'hC300 || out_y4 !== 16'h8700)
      $display("FAIL ser4_row1: got v=%b x=%h y=%h want v=10 x=c300 y=8700", out_valid4, out_x4, out_y4);
    else n_pass++;
    step();
    n_chk++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || out_valid4 !== 2'b00)
      $display("FAIL ser4_done: got done=%b busy=%b v=%b want 1/0/00", done4, busy4, out_valid4);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spec_example();
    test_random_loads();
    test_overflow();
    test_partial();
    test_replay();
    test_back_to_back();
    test_reset_mid_xfer();
    test_ser4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
